ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte, such as 0xED for set LEDs or 0xFF for reset, from the FPGA to the keyboard over the shared open-drain PS/2 clock and data lines. It is the counterpart of the keyboard receive path. It sits beside `ps2_keyboard` at the top level: system logic hands it a byte through a valid/ready handshake, and it runs the inhibit, request-to-send, bit-shift and acknowledge sequence. While `o_busy` is high, the top level must ignore frames seen by the receiver.

---
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx: sends one command byte from the host to a PS/2 device.
// Runs inhibit, request-to-send, LSB-first bit shift with odd parity,
// stop release and acknowledge sampling over the open-drain clock/data lines.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_low,
  output logic       o_ps2_data_low,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_nack,
  output logic       o_tx_timeout
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS_SETUP = 3'd2;
  localparam logic [2:0] S_RTS       = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE = 3'd6;

  logic [2:0]    state_q,    state_d;
  logic [IW-1:0] inhCnt_q,   inhCnt_d;
  logic [TW-1:0] tmoCnt_q,   tmoCnt_d;
  logic [3:0]    bitIdx_q,   bitIdx_d;
  logic [8:0]    shift_q,    shift_d;
  logic          clkLow_q,   clkLow_d;
  logic          dataLow_q,  dataLow_d;
  logic          done_q,     done_d;
  logic          nack_q,     nack_d;
  logic          timeout_q,  timeout_d;

  logic clkSync1_q, clkSync2_q, clkPrev_q, fall_q;
  logic dataSync1_q, dataSync2_q;
  logic txReady;
  logic tmoActive;

  assign txReady        = (state_q == S_IDLE) && !done_q;
  assign o_tx_ready     = txReady;
  assign o_busy         = (state_q != S_IDLE);
  assign o_ps2_clk_low  = clkLow_q;
  assign o_ps2_data_low = dataLow_q;
  assign o_tx_done      = done_q;
  assign o_tx_nack      = nack_q;
  assign o_tx_timeout   = timeout_q;

  // Two-flop synchronisers on both lines plus a registered falling-edge strobe.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      clkSync1_q  <= 1'b1;
      clkSync2_q  <= 1'b1;
      clkPrev_q   <= 1'b1;
      fall_q      <= 1'b0;
      dataSync1_q <= 1'b1;
      dataSync2_q <= 1'b1;
    end else begin
      clkSync1_q  <= i_ps2_clk;
      clkSync2_q  <= clkSync1_q;
      clkPrev_q   <= clkSync2_q;
      fall_q      <= clkPrev_q & ~clkSync2_q;
      dataSync1_q <= i_ps2_data;
      dataSync2_q <= dataSync1_q;
    end
  end

  // Transfer sequencer: next state, line drives, counters and completion flags.
  always_comb begin
    state_d   = state_q;
    inhCnt_d  = inhCnt_q;
    tmoCnt_d  = tmoCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    clkLow_d  = clkLow_q;
    dataLow_d = dataLow_q;
    done_d    = 1'b0;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    tmoActive = (state_q == S_RTS) || (state_q == S_DATA) ||
                (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    if ((tmoActive || state_q == S_RTS_SETUP) && tmoCnt_q != TIMEOUT_LAST) begin
      tmoCnt_d = tmoCnt_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        clkLow_d  = 1'b0;
        dataLow_d = 1'b0;
        if (i_tx_valid && txReady) begin
          shift_d   = {~^i_tx_data, i_tx_data};
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          inhCnt_d  = '0;
          clkLow_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inhCnt_q == INHIBIT_LAST) begin
          dataLow_d = 1'b1;
          tmoCnt_d  = '0;
          state_d   = S_RTS_SETUP;
        end else begin
          inhCnt_d = inhCnt_q + IW'(1);
        end
      end
      S_RTS_SETUP: begin
        clkLow_d = 1'b0;
        bitIdx_d = 4'd0;
        state_d  = S_RTS;
      end
      S_RTS: begin
        if (fall_q) begin
          dataLow_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          bitIdx_d  = 4'd1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (fall_q) begin
          if (bitIdx_q == 4'd9) begin
            dataLow_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            dataLow_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bitIdx_d  = bitIdx_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fall_q) begin
          nack_d  = dataSync2_q;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clkSync2_q && dataSync2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        clkLow_d  = 1'b0;
        dataLow_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // An expired timeout overrides whatever the current state decided.
    if (tmoActive && tmoCnt_q == TIMEOUT_LAST) begin
      clkLow_d  = 1'b0;
      dataLow_d = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      nack_d    = nack_q;
      state_d   = S_IDLE;
    end
  end

  // State register with synchronous clear that releases both lines at once.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      state_q   <= S_IDLE;
      inhCnt_q  <= '0;
      tmoCnt_q  <= '0;
      bitIdx_q  <= 4'd0;
      shift_q   <= '0;
      clkLow_q  <= 1'b0;
      dataLow_q <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inhCnt_q  <= inhCnt_d;
      tmoCnt_q  <= tmoCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      clkLow_q  <= clkLow_d;
      dataLow_q <= dataLow_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// expected frames and completion flags are queued at stimulus time and
// compared by the device model and a separate done monitor.
module tb_ps2_host_tx;

  logic clock = 1'b0;
  logic reset;
  logic [7:0] txData;
  logic txValid;
  logic tmoValid;

  // Clock generation.
  always #5 clock = ~clock;

  // Main instance signals (wired-AND open-drain bus with the device model).
  logic hostReady, hostClkLow, hostDataLow, hostBusy, hostDone, hostNack, hostTimeout;
  logic devClkRel, devDataRel;
  wire  ps2Clk  = ~hostClkLow & devClkRel;
  wire  ps2Data = ~hostDataLow & devDataRel;

  // Timeout instance: no device attached, lines only pulled by the host.
  logic tReady, tClkLow, tDataLow, tBusy, tDone, tNack, tTimeout;
  wire  tPs2Clk  = ~tClkLow;
  wire  tPs2Data = ~tDataLow;

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
    .i_clk(clock), .i_clr(reset), .i_tx_data(txData), .i_tx_valid(txValid),
    .o_tx_ready(hostReady), .i_ps2_clk(ps2Clk), .i_ps2_data(ps2Data),
    .o_ps2_clk_low(hostClkLow), .o_ps2_data_low(hostDataLow), .o_busy(hostBusy),
    .o_tx_done(hostDone), .o_tx_nack(hostNack), .o_tx_timeout(hostTimeout)
  );

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(200)) dutTmo (
    .i_clk(clock), .i_clr(reset), .i_tx_data(txData), .i_tx_valid(tmoValid),
    .o_tx_ready(tReady), .i_ps2_clk(tPs2Clk), .i_ps2_data(tPs2Data),
    .o_ps2_clk_low(tClkLow), .o_ps2_data_low(tDataLow), .o_busy(tBusy),
    .o_tx_done(tDone), .o_tx_nack(tNack), .o_tx_timeout(tTimeout)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int doneCount = 0;
  logic [9:0] expFrameQ[$];
  logic [1:0] expStatusQ[$];

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Done monitor: pops the expected {nack, timeout} whenever the host ends a transfer.
  initial begin
    logic [1:0] exp;
    forever begin
      @(negedge clock);
      if (hostDone === 1'b1) begin
        doneCount++;
        if (expStatusQ.size() == 0) begin
          checkOutput("unexpected_done", 32'(1), 32'(0));
        end else begin
          exp = expStatusQ.pop_front();
          checkOutput("done_nack", 32'(hostNack), 32'(exp[1]));
          checkOutput("done_timeout", 32'(hostTimeout), 32'(exp[0]));
        end
      end
    end
  end

  // Offer a byte, check the inhibit window and RTS_SETUP, optionally poke 0x55 while busy.
  task automatic applyStimulus(input logic [7:0] b, input logic parityBit, input bit nack,
                               input bit pushExp, input bit injectBusy);
    int n = 0;
    if (pushExp) begin
      expFrameQ.push_back({1'b1, parityBit, b});
      expStatusQ.push_back({nack, 1'b0});
    end
    while (hostReady !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("ready_before_accept", 32'(hostReady), 32'(1));
    txData  = b;
    txValid = 1'b1;
    @(negedge clock);
    if (injectBusy) begin
      txData = 8'h55;
      checkOutput("ready_low_while_busy", 32'(hostReady), 32'(0));
    end else begin
      txValid = 1'b0;
    end
    n = 0;
    while (hostClkLow === 1'b1 && hostDataLow === 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("inhibit_cycles", 32'(n), 32'(8));
    checkOutput("rts_setup_drive", 32'({hostClkLow, hostDataLow}), 32'(2'b11));
    txValid = 1'b0;
  endtask

  // Device model: clocks at 1/40 of the system clock and samples data before each rise.
  task automatic deviceTransfer(input int falls, input bit nack);
    logic [9:0] frame;
    logic [9:0] exp;
    int n = 0;
    frame = '0;
    while (!(hostClkLow === 1'b0 && hostDataLow === 1'b1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checkOutput("rts_seen", 32'(0), 32'(1));
      return;
    end
    checkOutput("start_bit", 32'(ps2Data), 32'(0));
    for (int k = 1; k <= falls; k++) begin
      repeat (20) @(negedge clock);
      devClkRel = 1'b0;
      repeat (20) @(negedge clock);
      if (k == falls && falls < 11) return;
      if (k <= 10) frame[k-1] = ps2Data;
      devClkRel = 1'b1;
      if (k == 10 && !nack) devDataRel = 1'b0;
      if (k == 11) devDataRel = 1'b1;
    end
    if (expFrameQ.size() == 0) begin
      checkOutput("frame_expected", 32'(0), 32'(1));
    end else begin
      exp = expFrameQ.pop_front();
      checkOutput("frame", 32'(frame), 32'(exp));
    end
  endtask

  // Wait (bounded) for the done pulse and check the ready handoff around it.
  task automatic waitDone();
    int n = 0;
    while (hostDone !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (hostDone !== 1'b1) begin
      checkOutput("done_seen", 32'(0), 32'(1));
      return;
    end
    checkOutput("ready_in_done_cycle", 32'(hostReady), 32'(0));
    @(negedge clock);
    checkOutput("ready_after_done", 32'(hostReady), 32'(1));
  endtask

  // Global safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    logic [7:0] vecByte [4];
    logic       vecPar  [4];
    bit         vecNack [4];
    int n;
    int doneBefore;
    vecByte = '{8'hED, 8'hF4, 8'h00, 8'hA5};
    vecPar  = '{1'b1, 1'b0, 1'b1, 1'b1};
    vecNack = '{1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; txData = 8'h00; txValid = 1'b0; tmoValid = 1'b0;
    devClkRel = 1'b1; devDataRel = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_ready", 32'(hostReady), 32'(1));
    checkOutput("reset_busy", 32'(hostBusy), 32'(0));
    checkOutput("reset_drives", 32'({hostClkLow, hostDataLow}), 32'(0));
    checkOutput("reset_flags", 32'({hostDone, hostNack, hostTimeout}), 32'(0));
    checkOutput("reset_tmo_inst", 32'({tReady, tBusy, tClkLow, tDataLow}), 32'(4'b1000));
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecByte[i], vecPar[i], vecNack[i], 1'b1, (i == 1));
      deviceTransfer(11, vecNack[i]);
      waitDone();
      if (vecNack[i]) begin
        repeat (3) @(negedge clock);
        checkOutput("nack_held", 32'(hostNack), 32'(1));
      end
    end

    // Reset in the middle of the data phase.
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    deviceTransfer(4, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midreset_drives", 32'({hostClkLow, hostDataLow}), 32'(0));
    checkOutput("midreset_ready", 32'(hostReady), 32'(1));
    checkOutput("midreset_busy", 32'(hostBusy), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    devClkRel = 1'b1;
    doneBefore = doneCount;
    repeat (100) @(negedge clock);
    checkOutput("midreset_no_done", 32'(doneCount - doneBefore), 32'(0));

    // Timeout with a silent device.
    txData = 8'h12;
    tmoValid = 1'b1;
    @(negedge clock);
    tmoValid = 1'b0;
    n = 0;
    while (!(tClkLow === 1'b1 && tDataLow === 1'b1) && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("tmo_rts_setup_seen", 32'(n < 100), 32'(1));
    n = 0;
    while (n < 400) begin
      @(negedge clock);
      n++;
      if (tDone === 1'b1) break;
    end
    checkOutput("tmo_done_cycle", 32'(n), 32'(200));
    checkOutput("tmo_flag", 32'(tTimeout), 32'(1));
    checkOutput("tmo_nack", 32'(tNack), 32'(0));
    checkOutput("tmo_lines_released", 32'({tClkLow, tDataLow}), 32'(0));
    @(negedge clock);
    checkOutput("tmo_ready_next", 32'(tReady), 32'(1));

    repeat (5) @(negedge clock);
    checkOutput("queues_drained", 32'(expFrameQ.size() + expStatusQ.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
